// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter: default width, FSM states,
// requester indices and the round-robin winner selection.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // On a tie the requester that was not served last wins; otherwise the
  // only active requester wins. Callers only use the result when a req is high.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    logic w;
    if (r0 && r1) begin
      w = (last == REQ0) ? REQ1 : REQ0;
    end else if (r1) begin
      w = REQ1;
    end else begin
      w = REQ0;
    end
    return w;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One step of subtractive GCD. Purely combinational: given the current
// operands it reports whether the computation has terminated, the result
// if so, and the operands after one subtraction otherwise.
module gcd_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             term_o,
  output logic [WIDTH-1:0] res_o
);

  // Larger operand is always the minuend, so the subtraction cannot wrap.
  always_comb begin
    a_o    = a_i;
    b_o    = b_i;
    term_o = (a_i == b_i) || (a_i == '0) || (b_i == '0);
    // a==0 yields b (covers gcd(0,0)=0); otherwise a (covers b==0 and a==b).
    res_o  = (a_i == '0) ? b_i : a_i;
    if (a_i > b_i) begin
      a_o = a_i - b_i;
    end else begin
      b_o = b_i - a_i;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Two-requester GCD engine with a round-robin arbiter. One request is
// accepted in IDLE, reduced one subtraction per cycle in CALC, and the
// result is announced with a one-cycle done pulse from DONE.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sel_q, sel_d;   // requester currently being served
  logic             last_q, last_d; // requester served most recently
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_step, b_step, res_step;
  logic             term_step;
  logic             winner;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .b_i    (b_q),
    .a_o    (a_step),
    .b_o    (b_step),
    .term_o (term_step),
    .res_o  (res_step)
  );

  // Next-state, datapath and registered-output logic for the FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    winner  = pick_winner(req0, req1, last_q);
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d   = winner;
          a_d     = (winner == REQ1) ? x1 : x0;
          b_d     = (winner == REQ1) ? y1 : y0;
          gnt0_d  = (winner == REQ0);
          gnt1_d  = (winner == REQ1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (term_step) begin
          res_d   = res_step;
          done0_d = (sel_q == REQ0);
          done1_d = (sel_q == REQ1);
          state_d = ST_DONE;
        end else begin
          a_d = a_step;
          b_d = b_step;
        end
      end
      ST_DONE: begin
        // The pointer moves only here, so a tie seen during CALC/DONE
        // cannot influence the transaction already in flight.
        last_d  = sel_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sel_q   <= REQ0;
      last_q  <= REQ1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign res   = res_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: stimulus pushes the expected requester,
// result and latency per transaction; a monitor pops on every done pulse.
module tb_gcd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] res;

  gcd_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       idx;
    bit [7:0] res;
    int       lat;  // negedges from gnt sample to done sample
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: Euclid by remainder.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtractions before a==b or an operand is zero, counted in
  // bulk with division rather than one subtraction at a time.
  function automatic int ref_steps(input int a, input int b);
    int n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) begin
        if (a % b == 0) begin n += a / b - 1; a = b; end
        else begin n += a / b; a = a % b; end
      end else begin
        if (b % a == 0) begin n += b / a - 1; b = a; end
        else begin n += b / a; b = b % a; end
      end
    end
    return n;
  endfunction

  function automatic exp_t mk(input bit idx, input int a, input int b);
    exp_t e;
    e.idx = idx;
    e.res = 8'(ref_gcd(a, b));
    e.lat = ref_steps(a, b) + 1;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int mon_cyc = 0;
  int gnt_cyc = 0;
  bit in_flight = 1'b0;
  bit post_done = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) begin
        in_flight = 1'b0;
        post_done = 1'b0;
        check("done_in_reset", {30'd0, done0, done1}, 32'd0);
      end else begin
        check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
        check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        if (post_done) begin
          check("busy_after_done", {31'd0, busy}, 32'd0);
          post_done = 1'b0;
        end
        if (gnt0 || gnt1) begin
          if (in_flight || exp_q.size() == 0) begin
            check("unexpected_gnt", 32'd1, 32'd0);
          end else begin
            check("gnt_requester", {31'd0, gnt1}, {31'd0, exp_q[0].idx});
            check("busy_at_gnt", {31'd0, busy}, 32'd1);
            in_flight = 1'b1;
            gnt_cyc = mon_cyc;
          end
        end else if (in_flight) begin
          check("busy_in_flight", {31'd0, busy}, 32'd1);
        end
        if (done0 || done1) begin
          if (!in_flight || exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_requester", {31'd0, done1}, {31'd0, e.idx});
            check("res", {24'd0, res}, {24'd0, e.res});
            check("latency", mon_cyc - gnt_cyc, e.lat);
            $display("txn req%0d res=%0d latency=%0d (exp res=%0d lat=%0d)",
                     done1, res, mon_cyc - gnt_cyc, e.res, e.lat);
            in_flight = 1'b0;
            post_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_gnt(input int limit, output int waited);
    waited = 0;
    while (waited < limit) begin
      @(negedge clk);
      waited++;
      if (gnt0 || gnt1) return;
    end
    check("gnt_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    exp_q.delete();
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single(input bit idx, input int a, input int b);
    int w;
    @(negedge clk);
    if (idx) begin x1 = 8'(a); y1 = 8'(b); req1 = 1'b1; end
    else begin x0 = 8'(a); y0 = 8'(b); req0 = 1'b1; end
    exp_q.push_back(mk(idx, a, b));
    model_last = idx;
    wait_gnt(10, w);
    check("accept_delay", w, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_empty(600);
  endtask

  // Both requesters tie; each drops its req once granted.
  task automatic pair(input int a0, input int b0, input int a1, input int b1);
    int w;
    bit win;
    @(negedge clk);
    x0 = 8'(a0); y0 = 8'(b0); x1 = 8'(a1); y1 = 8'(b1);
    req0 = 1'b1; req1 = 1'b1;
    win = ~model_last;
    exp_q.push_back(win ? mk(1'b1, a1, b1) : mk(1'b0, a0, b0));
    exp_q.push_back(win ? mk(1'b0, a0, b0) : mk(1'b1, a1, b1));
    model_last = ~win;
    wait_gnt(10, w);
    if (win) req1 = 1'b0; else req0 = 1'b0;
    wait_gnt(600, w);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_empty(600);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int mode, a0, b0, a1, b1;
    #1;
    check("reset_outputs", {24'd0, gnt0, gnt1, done0, done1, busy, 3'd0},  32'd0);
    check("reset_res", {24'd0, res}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    single(1'b0, 86, 84);
    single(1'b1, 255, 1);
    single(1'b0, 0, 0);
    single(1'b1, 0, 12);
    single(1'b0, 45, 45);
    single(1'b1, 200, 0);

    // Simultaneous requests held high right after reset: 0, 1, 0.
    do_reset();
    @(negedge clk);
    x0 = 8'd12; y0 = 8'd34; x1 = 8'd10; y1 = 8'd30;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit win;
      win = ~model_last;
      exp_q.push_back(win ? mk(1'b1, 10, 30) : mk(1'b0, 12, 34));
      model_last = win;
    end
    for (int k = 0; k < 3; k++) wait_gnt(600, w);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_empty(600);

    // Reset in the middle of a long calculation.
    @(negedge clk);
    x1 = 8'd255; y1 = 8'd1; req1 = 1'b1;
    exp_q.push_back(mk(1'b1, 255, 1));
    wait_gnt(10, w);
    req1 = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_last = 1'b1;
    #1;
    check("midcalc_reset_outputs", {24'd0, gnt0, gnt1, done0, done1, busy, 3'd0}, 32'd0);
    check("midcalc_reset_res", {24'd0, res}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", {30'd0, done0, done1}, 32'd0);
    single(1'b0, 57, 34);

    // Randomized mix of single and tied requests.
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 2);
      a0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      b0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      a1 = $urandom_range(0, 255);
      b1 = $urandom_range(1, 255);
      if (mode == 2) pair(a0, b0, a1, b1);
      else single(mode[0], a0, b0);
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
